// File: rtl/iter_divider_pkg.sv
// Shared widths and state encoding for the iterative divider.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring division iteration: shift, trial subtract, restore on borrow.
module div_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;

  // Extra headroom bit keeps the borrow visible for any divisor.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {2'b00, divisor};
  assign neg     = diff[WIDTH+1];

  assign rem_out = neg ? shifted[WIDTH:0] : diff[WIDTH:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~neg};

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring DIV/DIVU: quotient to LO (q), remainder to HI (r).
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             DIV_clk,
  input  logic             DIV_rst,
  input  logic             DIV_ena,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] rem_lo;

  // Magnitude of the most negative value wraps to itself, read as unsigned.
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign rem_lo = step_rem[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          raw_d   = dividend;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dz_d    = (divisor == '0);
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (dz_q) begin
            q_d = '1;
            r_d = raw_q;
          end else begin
            q_d = negq_q ? -step_quo : step_quo;
            r_d = negr_q ? -rem_lo : rem_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DIV_clk or posedge DIV_rst) begin
    if (DIV_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else if (DIV_ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == BUSY);
  assign done = done_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider at WIDTH=32 and WIDTH=8.
module tb_iter_divider;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;

  logic        start8;
  logic        sgn8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        busy8;
  logic        done8;

  int n_pass;
  int n_tot;

  iter_divider #(.WIDTH(32)) dut (
    .DIV_clk(clk), .DIV_rst(rst), .DIV_ena(ena),
    .start(start), .is_signed(sgn),
    .dividend(a), .divisor(b),
    .q(q), .r(r), .busy(busy), .done(done)
  );

  iter_divider #(.WIDTH(8)) dut8 (
    .DIV_clk(clk), .DIV_rst(rst), .DIV_ena(ena),
    .start(start8), .is_signed(sgn8),
    .dividend(a8), .divisor(b8),
    .q(q8), .r(r8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drives start for one edge, then counts edges until done (bounded).
  task automatic run32(input logic s, input logic [31:0] x,
                       input logic [31:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] x,
                      input logic [7:0] y, output int lat);
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vt[12];
  vec_t v8[3];

  initial begin
    int  lat;
    int  lat2;
    bit  seen;
    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1; ena = 1'b1; start = 1'b0; sgn = 1'b0;
    a = '0; b = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;

    vt[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    vt[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vt[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vt[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vt[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vt[5]  = '{1'b0, 32'h1234,       32'd0,        32'hFFFF_FFFF, 32'h1234};
    vt[6]  = '{1'b1, 32'h1234,       32'd0,        32'hFFFF_FFFF, 32'h1234};
    vt[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};
    vt[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
    vt[9]  = '{1'b0, 32'd5,          32'd10,       32'd0,        32'd5};
    vt[10] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE};
    vt[11] = '{1'b1, 32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF0};

    v8[0] = '{1'b1, 32'h80, 32'hFF, 32'h80, 32'h00};
    v8[1] = '{1'b0, 32'd200, 32'd7, 32'd28, 32'd4};
    v8[2] = '{1'b1, 32'hF9, 32'h02, 32'hFD, 32'hFF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run32(vt[i].s, vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_q", i), q, vt[i].q);
      chk($sformatf("v%0d_r", i), r, vt[i].r);
      chk($sformatf("v%0d_lat", i), lat, 32'd32);
    end

    // Busy seen right after accept; a start pulse mid-operation is ignored.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("acc_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd999; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 10;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", lat, 32'd32);
    chk("ign_q", q, 32'd14);
    chk("ign_r", r, 32'd2);

    // Start presented during the done cycle is accepted.
    start = 1'b1; sgn = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_drop", {31'd0, done}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat2);
    chk("b2b_lat", lat2, 32'd32);
    chk("b2b_q", q, 32'hFFFF_FFFD);
    chk("b2b_r", r, 32'hFFFF_FFFF);

    // done is held while disabled, then drops on the next enabled edge.
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_done", {31'd0, done}, 32'd1);
    ena = 1'b1;
    @(posedge clk); #1;
    chk("drop_done", {31'd0, done}, 32'd0);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_q", q, 32'd0);
    chk("mrst_r", r, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("mrst_nodone", {31'd0, seen}, 32'd0);

    // Enable dropped for five edges mid-operation.
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; a = 32'd7; b = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ena_busy", {31'd0, busy}, 32'd1);
    chk("ena_nodone", {31'd0, done}, 32'd0);
    ena = 1'b1;
    lat = 15;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ena_lat", lat, 32'd37);
    chk("ena_q", q, 32'hFFFF_FFFD);
    chk("ena_r", r, 32'd1);

    for (int i = 0; i < 3; i++) begin
      run8(v8[i].s, v8[i].a[7:0], v8[i].b[7:0], lat);
      chk($sformatf("w8_%0d_q", i), {24'd0, q8}, v8[i].q);
      chk($sformatf("w8_%0d_r", i), {24'd0, r8}, v8[i].r);
      chk($sformatf("w8_%0d_lat", i), lat, 32'd8);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
